mdu_sequencer: RTL and testbench

- Multi-cycle multiply/divide sequencer for the pipelined MIPS core.
- Sits in the E stage beside the ALU and owns the HI/LO architectural registers.
- Takes the decoded MDU enable/opcode plus forwarded rs/rt operands, and models fixed MULT/DIV latency.
- Drives the busy flag that the controller's stall logic consumes, and supplies HI/LO to the E-stage result mux for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_arith.sv | 64 ++++++
 rtl/mdu_sequencer.sv | 158 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide sequencer.
//   - MDU opcode values as driven by the decoder
//   - sequencer FSM state type
//   - latency counter width
package mdu_pkg;

    localparam int unsigned MDU_OP_W  = 3;
    localparam int unsigned MDU_CNT_W = 4;

    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd1;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd3;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_t;

endpackage : mdu_pkg

// File: rtl/mdu_arith.sv
// mdu_arith: combinational multiply/divide result generator.
// Ports:
//   op     in  3   MDU opcode (only MULT/MULTU/DIV/DIVU produce results)
//   a, b   in  32  operands rs / rt
//   res_hi out 32  HI result (product high word or remainder)
//   res_lo out 32  LO result (product low word or quotient)
//   dz     out 1   divide op with b == 0
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    output logic [31:0]         res_hi,
    output logic [31:0]         res_lo,
    output logic                dz
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;

    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide is done on magnitudes so 0x80000000 / -1 never overflows.
    assign w_a_mag = a[31] ? 32'(32'd0 - a) : a;
    assign w_b_mag = b[31] ? 32'(32'd0 - b) : b;
    assign w_q_mag = w_a_mag / w_b_mag;
    assign w_r_mag = w_a_mag % w_b_mag;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        dz     = 1'b0;
        case (op)
            MDU_MULT: begin
                res_hi = w_prod_s[63:32];
                res_lo = w_prod_s[31:0];
            end
            MDU_MULTU: begin
                res_hi = w_prod_u[63:32];
                res_lo = w_prod_u[31:0];
            end
            MDU_DIV: begin
                // Quotient truncates toward zero; remainder follows the dividend.
                res_lo = (a[31] ^ b[31]) ? 32'(32'd0 - w_q_mag) : w_q_mag;
                res_hi = a[31] ? 32'(32'd0 - w_r_mag) : w_r_mag;
                dz     = (b == 32'd0);
            end
            MDU_DIVU: begin
                res_lo = a / b;
                res_hi = a % b;
                dz     = (b == 32'd0);
            end
            default: begin
            end
        endcase
    end

endmodule : mdu_arith

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: E-stage multi-cycle MULT/DIV sequencer owning HI/LO.
// Build option: define MDU_ABORT_EN to add the 'abort' flush input.
// Ports:
//   clk    in  1   core clock, rising edge
//   reset  in  1   asynchronous active-low reset
//   start  in  1   MDU enable from decode
//   op     in  3   MDU opcode (see mdu_pkg)
//   a, b   in  32  forwarded rs / rt operands
//   abort  in  1   (MDU_ABORT_EN only) cancel an in-flight op
//   busy   out 1   mult/div in progress
//   done   out 1   pulse in the cycle after HI/LO commit
//   hi, lo out 32  architectural HI / LO
//   reject out 1   pulse: start arrived while busy and was dropped
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
`ifdef MDU_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy,
    output logic                done,
    output logic [31:0]         hi,
    output logic [31:0]         lo,
    output logic                reject
);

    mdu_state_t           r_state, w_state;
    logic [MDU_CNT_W-1:0] r_cnt, w_cnt;
    logic [31:0]          r_hi, w_hi;
    logic [31:0]          r_lo, w_lo;
    logic [31:0]          r_sh_hi, w_sh_hi;
    logic [31:0]          r_sh_lo, w_sh_lo;
    logic                 r_sh_dz, w_sh_dz;
    logic                 r_done, w_done;
    logic                 r_reject, w_reject;

    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;
    logic                 w_dz;
    logic                 w_abort;

`ifdef MDU_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    mdu_arith u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .res_hi (w_res_hi),
        .res_lo (w_res_lo),
        .dz     (w_dz)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state;
    end

    // Next state, counter, shadow and HI/LO updates
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_hi     = r_hi;
        w_lo     = r_lo;
        w_sh_hi  = r_sh_hi;
        w_sh_lo  = r_sh_lo;
        w_sh_dz  = r_sh_dz;
        w_done   = 1'b0;
        w_reject = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !w_abort) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            w_sh_hi = w_res_hi;
                            w_sh_lo = w_res_lo;
                            w_sh_dz = 1'b0;
                            w_cnt   = MDU_CNT_W'(MULT_LAT - 1);
                            w_state = S_BUSY;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            w_sh_hi = w_res_hi;
                            w_sh_lo = w_res_lo;
                            w_sh_dz = w_dz;
                            w_cnt   = MDU_CNT_W'(DIV_LAT - 1);
                            w_state = S_BUSY;
                        end
                        MDU_MTHI: w_hi = a;
                        MDU_MTLO: w_lo = a;
                        default: begin
                        end
                    endcase
                end
            end
            S_BUSY: begin
                // The commit edge still counts as busy, so a start there is dropped.
                w_reject = start;
                if (w_abort) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end else if (r_cnt == '0) begin
                    if (!r_sh_dz) begin
                        w_hi = r_sh_hi;
                        w_lo = r_sh_lo;
                    end
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt - MDU_CNT_W'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_sh_hi  <= 32'd0;
            r_sh_lo  <= 32'd0;
            r_sh_dz  <= 1'b0;
            r_done   <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_cnt    <= w_cnt;
            r_hi     <= w_hi;
            r_lo     <= w_lo;
            r_sh_hi  <= w_sh_hi;
            r_sh_lo  <= w_sh_lo;
            r_sh_dz  <= w_sh_dz;
            r_done   <= w_done;
            r_reject <= w_reject;
        end
    end

    assign busy   = (r_state == S_BUSY);
    assign done   = r_done;
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign reject = r_reject;

endmodule : mdu_sequencer

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: scoreboard bench for mdu_sequencer.
// Stimulus pushes the expected {HI,LO} of each MULT/DIV into a queue; a
// monitor pops and compares on every done pulse. Build with MDU_ABORT_EN
// to also exercise the abort input.
module tb_mdu_sequencer;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        reject;
`ifdef MDU_ABORT_EN
    logic        abort;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_issued = 0;
    int          n_done   = 0;
    bit          rej_allow = 1'b0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_exp;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_sequencer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
`ifdef MDU_ABORT_EN
        .abort  (abort),
`endif
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .reject (reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result from plain 64-bit arithmetic; divide by zero keeps old HI/LO.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [31:0] oh,
                                               input logic [31:0] ol);
        longint          sx, sy, q, r;
        longint unsigned ux, uy;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: return 64'(sx * sy);
            3'd1: return ux * uy;
            3'd2: begin
                if (y == 32'd0) return {oh, ol};
                q = sx / sy;
                r = sx % sy;
                return {32'(r), 32'(q)};
            end
            3'd3: begin
                if (y == 32'd0) return {oh, ol};
                return {32'(ux % uy), 32'(ux / uy)};
            end
            default: return {oh, ol};
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (done) begin
                n_done++;
                if (sb_q.size() == 0) begin
                    check("done_without_pending_op", 64'(done), 64'(0));
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("hilo_at_done", {hi, lo}, mon_exp);
                end
            end
            if (reject && !rej_allow) check("reject_unexpected", 64'(reject), 64'(0));
        end
    end

    // Issue one op in the current cycle; for MULT/DIV follow it until busy drops.
    // poke: fire an MTLO into the busy window and expect it to be rejected.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit poke);
        logic [31:0] oh, ol;
        logic [63:0] res;
        int          cyc;
        int unsigned lat;
        oh    = m_hi;
        ol    = m_lo;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
        if (o <= 3'd3) begin
            res = ref_result(o, x, y, oh, ol);
            {m_hi, m_lo} = res;
            sb_q.push_back(res);
            n_issued++;
            lat = (o <= 3'd1) ? MULT_LAT : DIV_LAT;
            cyc = 0;
            while (busy && cyc < 40) begin
                cyc++;
                if (cyc == 1) check("hilo_hold_while_busy", {hi, lo}, {oh, ol});
                if (poke && cyc == 2) begin
                    rej_allow = 1'b1;
                    start     = 1'b1;
                    op        = 3'd5;
                    a         = $urandom;
                end
                if (poke && cyc == 3) begin
                    start = 1'b0;
                    check("reject_pulse", 64'(reject), 64'(1));
                end
                @(negedge clk);
            end
            check("busy_cycles", 64'(cyc), 64'(lat));
            check("hilo_after_busy", {hi, lo}, res);
            rej_allow = 1'b0;
        end else begin
            if (o == 3'd4) m_hi = x;
            if (o == 3'd5) m_lo = x;
            check("busy_on_idle_op", 64'(busy), 64'(0));
            check("hilo_idle_op", {hi, lo}, {m_hi, m_lo});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
`ifdef MDU_ABORT_EN
        abort = 1'b0;
`endif
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy",   64'(busy),   64'(0));
        check("reset_done",   64'(done),   64'(0));
        check("reset_reject", 64'(reject), 64'(0));
        check("reset_hilo",   {hi, lo},    64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed arithmetic cases with hand-computed results
        do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu_big", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd3, 32'd7, 32'd0, 1'b0);
        check("divu_by_zero", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi", 64'(hi), 64'h1234_5678);
        do_op(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);
        check("mtlo", 64'(lo), 64'hCAFE_F00D);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op(3'd6, 32'h1111_1111, 32'd5, 1'b0);
        do_op(3'd7, 32'h2222_2222, 32'd5, 1'b0);

        // MTLO while DIV is busy must be dropped
        do_op(3'd2, 32'd100, 32'd7, 1'b1);
        check("div_with_reject", {hi, lo}, {32'd2, 32'd14});

        // Back-to-back MULTs issued in the cycle busy falls
        do_op(3'd0, 32'd1000, 32'hFFFF_FFFF, 1'b0);
        do_op(3'd0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        check("b2b_second", {hi, lo}, 64'h0000_0001_0000_0000);

        // Asynchronous reset in the middle of a DIV
        start = 1'b1;
        op    = 3'd2;
        a     = 32'd50;
        b     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_reset", 64'(busy), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy), 64'(0));
        check("async_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        @(negedge clk);

`ifdef MDU_ABORT_EN
        // Load known HI/LO, then abort a MULT in its third busy cycle
        do_op(3'd4, 32'hA5A5_0001, 32'd0, 1'b0);
        start = 1'b1;
        op    = 3'd0;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_hilo", {hi, lo}, {m_hi, m_lo});
        repeat (MULT_LAT + 2) @(negedge clk);
        check("abort_hilo_later", {hi, lo}, {m_hi, m_lo});
`endif

        // Randomized ops including divide by zero and reserved opcodes
        for (int i = 0; i < 60; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 9));
            do_op(r_op, r_a, r_b, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(n_issued));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mdu_sequencer
